// File: rtl/alias_bus_reader.sv
// alias_bus_reader
//
// Reader end of an aliased shared bus. On a start request it waits until the
// three views a/b/c agree and stay unchanged for STABLE_CYCLES consecutive
// cycles. It then samples the word and compares it against EXPECT. If the bus
// never settles within TIMEOUT cycles, it reports a timeout instead.
//
// Ports
//   clk        : sole clock, rising edge
//   rst_n      : asynchronous active-low reset
//   start      : begin a check (honoured only while idle)
//   a, b, c    : three views of the aliased bus
//   busy       : high whenever a check is in flight (state != IDLE)
//   done       : one-cycle pulse, result outputs are valid
//   pass       : last check passed
//   timeout    : last check never reached stability
//   mismatch   : bit0 a!=EXPECT, bit1 b!=a, bit2 c!=a
//   data       : value of a sampled by the last check
//   err_count  : failed checks since reset, saturating
module alias_bus_reader #(
  parameter int              WIDTH         = 32,
  parameter logic [WIDTH-1:0] EXPECT       = 32'hdeadbeef,
  parameter int              STABLE_CYCLES = 4,
  parameter int              TIMEOUT       = 64,
  parameter int              CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [2:0]       mismatch,
  output logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] err_count
);

  // Counters are sized to hold their terminal values without wrapping.
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam int STB_W = $clog2(STABLE_CYCLES + 1);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_prev;
  logic [STB_W-1:0] r_stab_cnt;
  logic [TMR_W-1:0] r_timer;
  logic             r_pass;
  logic             r_timeout;
  logic [2:0]       r_mismatch;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_err_count;

  logic             w_steady;
  logic [2:0]       w_cmp;
  logic             w_stable_exit;
  logic             w_timer_exit;

  // Steady means all views agree now and a has not moved since last cycle.
  assign w_steady      = (a == b) && (a == c) && (a == r_prev);
  assign w_cmp         = {c != a, b != a, a != EXPECT};
  assign w_stable_exit = w_steady && (r_stab_cnt == STB_LAST);
  assign w_timer_exit  = (r_timer == TMR_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; stability takes priority over the timeout.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (w_stable_exit) begin
          w_state_next = S_CHECK;
        end else if (w_timer_exit) begin
          w_state_next = S_DONE;
        end
      end
      S_CHECK: w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: settle tracking and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev      <= '0;
      r_stab_cnt  <= '0;
      r_timer     <= '0;
      r_pass      <= 1'b0;
      r_timeout   <= 1'b0;
      r_mismatch  <= '0;
      r_data      <= '0;
      r_err_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_prev     <= a;
            r_stab_cnt <= '0;
            r_timer    <= '0;
          end
        end
        S_SETTLE: begin
          r_prev     <= a;
          r_timer    <= r_timer + 1'b1;
          r_stab_cnt <= w_steady ? r_stab_cnt + 1'b1 : '0;
          if (!w_stable_exit && w_timer_exit) begin
            r_timeout  <= 1'b1;
            r_pass     <= 1'b0;
            r_mismatch <= w_cmp;
            r_data     <= a;
            if (r_err_count != CNT_MAX) begin
              r_err_count <= r_err_count + 1'b1;
            end
          end
        end
        S_CHECK: begin
          r_data     <= a;
          r_mismatch <= w_cmp;
          r_pass     <= (w_cmp == 3'b000);
          r_timeout  <= 1'b0;
          if ((w_cmp != 3'b000) && (r_err_count != CNT_MAX)) begin
            r_err_count <= r_err_count + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign pass      = r_pass;
  assign timeout   = r_timeout;
  assign mismatch  = r_mismatch;
  assign data      = r_data;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_alias_bus_reader.sv
// Directed bench for alias_bus_reader: nominal pass, value mismatch, timeout,
// glitch restart, reset abort, ignored start, and a narrow saturating counter.
module tb_alias_bus_reader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        start2;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] c;

  logic        busy;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [2:0]  mismatch;
  logic [31:0] data;
  logic [7:0]  err_count;

  logic        busy2;
  logic        done2;
  logic        pass2;
  logic        timeout2;
  logic [2:0]  mismatch2;
  logic [31:0] data2;
  logic [1:0]  err_count2;

  int checks;
  int errors;
  int lat;
  int done_seen;

  alias_bus_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .c         (c),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .timeout   (timeout),
    .mismatch  (mismatch),
    .data      (data),
    .err_count (err_count)
  );

  alias_bus_reader #(.CNT_W(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start2),
    .a         (a),
    .b         (b),
    .c         (c),
    .busy      (busy2),
    .done      (done2),
    .pass      (pass2),
    .timeout   (timeout2),
    .mismatch  (mismatch2),
    .data      (data2),
    .err_count (err_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulses start for one edge (edge N) and returns k where done is first
  // seen high after edge N+k, or -1 if it never appears within max_edges.
  // With glitch set, the bus reads 0 only at edge N+2.
  task automatic run_check(input int max_edges, input bit glitch, output int k);
    logic [31:0] sa, sb, sc;
    sa = a; sb = b; sc = c;
    k = -1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= max_edges; i++) begin
      @(posedge clk);
      #1;
      if (glitch && i == 1) begin
        a = '0; b = '0; c = '0;
      end
      if (glitch && i == 2) begin
        a = sa; b = sb; c = sc;
      end
      if (done) begin
        k = i;
        break;
      end
    end
    $display("check: latency=%0d pass=%0b timeout=%0b mismatch=%03b data=%08h err_count=%0d",
             k, pass, timeout, mismatch, data, err_count);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    start2 = 1'b0;
    a = '0; b = '0; c = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pass", 64'(pass), 64'd0);
    chk("rst_err",  64'(err_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Steady expected value: pass after 5 edges
    a = 32'hdeadbeef; b = 32'hdeadbeef; c = 32'hdeadbeef;
    run_check(20, 1'b0, lat);
    chk("good_lat",      64'(lat), 64'd5);
    chk("good_busy",     64'(busy), 64'd1);
    chk("good_pass",     64'(pass), 64'd1);
    chk("good_mismatch", 64'(mismatch), 64'd0);
    chk("good_data",     64'(data), 64'hdeadbeef);
    chk("good_err",      64'(err_count), 64'd0);
    chk("good_timeout",  64'(timeout), 64'd0);
    @(posedge clk);
    #1;
    chk("good_done_pulse", 64'(done), 64'd0);
    chk("good_hold_pass",  64'(pass), 64'd1);

    // Steady but wrong value
    a = 32'h12345678; b = 32'h12345678; c = 32'h12345678;
    run_check(20, 1'b0, lat);
    chk("bad_lat",      64'(lat), 64'd5);
    chk("bad_pass",     64'(pass), 64'd0);
    chk("bad_mismatch", 64'(mismatch), 64'b001);
    chk("bad_data",     64'(data), 64'h12345678);
    chk("bad_err",      64'(err_count), 64'd1);

    // c never agrees: timeout after 64 edges
    a = 32'hdeadbeef; b = 32'hdeadbeef; c = 32'h0;
    run_check(100, 1'b0, lat);
    chk("to_lat",      64'(lat), 64'd64);
    chk("to_timeout",  64'(timeout), 64'd1);
    chk("to_pass",     64'(pass), 64'd0);
    chk("to_mismatch", 64'(mismatch), 64'b100);
    chk("to_data",     64'(data), 64'hdeadbeef);
    chk("to_err",      64'(err_count), 64'd2);

    // One-cycle glitch at edge N+2 restarts the stability count
    c = 32'hdeadbeef;
    run_check(30, 1'b1, lat);
    chk("gl_lat",      64'(lat), 64'd8);
    chk("gl_pass",     64'(pass), 64'd1);
    chk("gl_timeout",  64'(timeout), 64'd0);
    chk("gl_mismatch", 64'(mismatch), 64'd0);
    chk("gl_err",      64'(err_count), 64'd2);

    // Reset during SETTLE aborts the check
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("ar_busy",     64'(busy), 64'd0);
    chk("ar_done",     64'(done), 64'd0);
    chk("ar_pass",     64'(pass), 64'd0);
    chk("ar_timeout",  64'(timeout), 64'd0);
    chk("ar_mismatch", 64'(mismatch), 64'd0);
    chk("ar_data",     64'(data), 64'd0);
    chk("ar_err",      64'(err_count), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) done_seen++;
    end
    chk("ar_no_done", 64'(done_seen), 64'd0);
    $display("check: reset abort, activity_cycles=%0d", done_seen);

    // Fresh start; extra start pulses in SETTLE and in DONE are ignored
    lat = -1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) start = 1'b1;
      if (i == 2) start = 1'b0;
      if (done) begin
        lat = i;
        break;
      end
    end
    chk("fr_lat",  64'(lat), 64'd5);
    chk("fr_pass", 64'(pass), 64'd1);
    chk("fr_err",  64'(err_count), 64'd0);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("fr_done_ignore", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    chk("fr_still_idle", 64'(busy), 64'd0);
    $display("check: fresh start latency=%0d pass=%0b busy=%0b", lat, pass, busy);

    // Two-bit counter saturates at 3
    a = 32'h12345678; b = 32'h12345678; c = 32'h12345678;
    for (int k = 1; k <= 5; k++) begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      start2 = 1'b1;
      @(posedge clk);
      #1 start2 = 1'b0;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
        @(posedge clk);
        #1;
        if (done2) begin
          lat = i;
          break;
        end
      end
      chk("sat_lat", 64'(lat), 64'd5);
      chk("sat_err", 64'(err_count2), 64'((k < 3) ? k : 3));
      $display("check: sat run %0d latency=%0d err_count=%0d", k, lat, err_count2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
